// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Shares one combinational 64-bit vector ALU between two requesters (e.g. the
// core pipeline and the NIC/NoC packet path).
//
// Operation
//   - Requests are arbitrated round-robin.
//   - The winning op is registered onto the ALU inputs.
//   - The ALU inputs are held for an op-dependent number of cycles:
//       MUL_LAT for ops 8..11, ALU_LAT for every other op.
//   - The ALU result is captured into a response register.
//   - The response is returned with the requester id and an error flag over a
//     valid/ready channel.
//   - Bit 0 is the MSB on every bus, matching the alu module.
//
// Ports
//   clk, reset_n                     clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready          request handshake for requester N (N=0,1)
//   reqN_op/ww/oprA/oprB/shamt       request fields, don't-care while valid=0
//   alu_oprA/oprB/shift_amount/op/ww registered ALU inputs, held between ops
//   alu_result                       combinational result from the ALU
//   rsp_valid / rsp_ready            response handshake
//   rsp_id, rsp_data, rsp_err        response payload
//   ops_done                         completed-response counter (wraps)
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int MUL_LAT = 2,   // 1..15
    parameter int ALU_LAT = 1,   // 1..15
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [0:5]       req0_op,
    input  logic [0:1]       req0_ww,
    input  logic [0:63]      req0_oprA,
    input  logic [0:63]      req0_oprB,
    input  logic [0:4]       req0_shamt,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [0:5]       req1_op,
    input  logic [0:1]       req1_ww,
    input  logic [0:63]      req1_oprA,
    input  logic [0:63]      req1_oprB,
    input  logic [0:4]       req1_shamt,

    output logic [0:63]      alu_oprA,
    output logic [0:63]      alu_oprB,
    output logic [0:4]       alu_shift_amount,
    output logic [0:5]       alu_op,
    output logic [0:1]       alu_ww,
    input  logic [0:63]      alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [0:63]      rsp_data,
    output logic             rsp_err,
    output logic [0:CNT_W-1] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Hold counter is loaded with L-1 so that the result is captured exactly
    // L cycles after the accepting edge.
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] ALU_CNT = 4'(ALU_LAT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_grant;
    logic [3:0]       r_cnt;

    logic [0:63]      r_alu_oprA;
    logic [0:63]      r_alu_oprB;
    logic [0:4]       r_alu_shamt;
    logic [0:5]       r_alu_op;
    logic [0:1]       r_alu_ww;

    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [0:63]      r_rsp_data;
    logic             r_rsp_err;
    logic [0:CNT_W-1] r_ops_done;

    // ------------------------------------------------------------------
    // Arbitration: a sole requester wins. On a tie, the requester that did
    // not win last time wins.
    // ------------------------------------------------------------------
    logic        w_grant_vld;
    logic        w_grant_id;
    logic [0:5]  w_sel_op;
    logic [0:1]  w_sel_ww;
    logic [0:63] w_sel_oprA;
    logic [0:63] w_sel_oprB;
    logic [0:4]  w_sel_shamt;
    logic        w_is_mul;
    logic        w_illegal;
    logic        w_exec_done;
    logic        w_rsp_hs;

    assign w_grant_vld = req0_valid | req1_valid;
    assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    assign w_sel_op    = w_grant_id ? req1_op    : req0_op;
    assign w_sel_ww    = w_grant_id ? req1_ww    : req0_ww;
    assign w_sel_oprA  = w_grant_id ? req1_oprA  : req0_oprA;
    assign w_sel_oprB  = w_grant_id ? req1_oprB  : req0_oprB;
    assign w_sel_shamt = w_grant_id ? req1_shamt : req0_shamt;

    // Ops 8..11 are the even/odd multiply and square family.
    // These ops have no doubleword form.
    assign w_is_mul  = (w_sel_op >= 6'd8) && (w_sel_op <= 6'd11);
    assign w_illegal = (w_sel_op == 6'd0) || (w_sel_op > 6'd18) ||
                       (w_is_mul && (w_sel_ww == 2'd3));

    assign w_exec_done = (r_state == EXEC) && (r_cnt == 4'd0);
    assign w_rsp_hs    = (r_state == RESP) && rsp_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_vld) w_state_next = EXEC;
            EXEC:    if (w_exec_done) w_state_next = RESP;
            RESP:    if (rsp_ready)   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Ready goes only to the granted requester, and only in
    // IDLE. Because of this, the handshake cycle in RESP never accepts.
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (r_state == IDLE && w_grant_vld) begin
            req0_ready = ~w_grant_id;
            req1_ready =  w_grant_id;
        end
    end

    // ------------------------------------------------------------------
    // Datapath.
    // ALU inputs change only on accept, so they keep the last op's values
    // through EXEC, RESP and IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_alu_oprA   <= '0;
            r_alu_oprB   <= '0;
            r_alu_shamt  <= '0;
            r_alu_op     <= '0;
            r_alu_ww     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_ops_done   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_alu_oprA   <= w_sel_oprA;
                        r_alu_oprB   <= w_sel_oprB;
                        r_alu_shamt  <= w_sel_shamt;
                        r_alu_op     <= w_sel_op;
                        r_alu_ww     <= w_sel_ww;
                        r_rsp_id     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_rsp_err    <= w_illegal;
                        r_cnt        <= w_is_mul ? MUL_CNT : ALU_CNT;
                    end
                end
                EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_data  <= alu_result;
                        r_rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_oprA         = r_alu_oprA;
    assign alu_oprB         = r_alu_oprB;
    assign alu_shift_amount = r_alu_shamt;
    assign alu_op           = r_alu_op;
    assign alu_ww           = r_alu_ww;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_id           = r_rsp_id;
    assign rsp_data         = r_rsp_data;
    assign rsp_err          = r_rsp_err;
    assign ops_done         = r_ops_done;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Directed testbench for alu_issue_ctrl.
//   - A tiny ALU stand-in answers VADD.W (op 6), VMULEU.W (op 8) and returns
//     0 for everything else.
//   - Expected response values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int MUL_LAT = 2;
    localparam int ALU_LAT = 1;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             reset_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [0:5]       req0_op, req1_op;
    logic [0:1]       req0_ww, req1_ww;
    logic [0:63]      req0_oprA, req0_oprB, req1_oprA, req1_oprB;
    logic [0:4]       req0_shamt, req1_shamt;
    logic [0:63]      alu_oprA, alu_oprB, alu_result;
    logic [0:4]       alu_shift_amount;
    logic [0:5]       alu_op;
    logic [0:1]       alu_ww;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [0:63]      rsp_data;
    logic [0:CNT_W-1] ops_done;

    int n_tests;
    int n_fail;
    int exp_done;

    alu_issue_ctrl #(
        .MUL_LAT (MUL_LAT),
        .ALU_LAT (ALU_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_op          (req0_op),
        .req0_ww          (req0_ww),
        .req0_oprA        (req0_oprA),
        .req0_oprB        (req0_oprB),
        .req0_shamt       (req0_shamt),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_op          (req1_op),
        .req1_ww          (req1_ww),
        .req1_oprA        (req1_oprA),
        .req1_oprB        (req1_oprB),
        .req1_shamt       (req1_shamt),
        .alu_oprA         (alu_oprA),
        .alu_oprB         (alu_oprB),
        .alu_shift_amount (alu_shift_amount),
        .alu_op           (alu_op),
        .alu_ww           (alu_ww),
        .alu_result       (alu_result),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .ops_done         (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: word add / even-word unsigned multiply; all else gives 0.
    logic [63:0] mul_a, mul_b;
    always_comb begin
        mul_a      = {32'h0, alu_oprA[0:31]};
        mul_b      = {32'h0, alu_oprB[0:31]};
        alu_result = '0;
        if (alu_op == 6'd6 && alu_ww == 2'd2)
            alu_result = {alu_oprA[0:31] + alu_oprB[0:31], alu_oprA[32:63] + alu_oprB[32:63]};
        else if (alu_op == 6'd8 && alu_ww == 2'd2)
            alu_result = mul_a * mul_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input logic [5:0] op, input logic [1:0] ww,
                         input logic [63:0] a, input logic [63:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_ww = ww;
            req0_oprA = a;  req0_oprB = b; req0_shamt = a[4:0];
        end else begin
            req1_valid = v; req1_op = op; req1_ww = ww;
            req1_oprA = a;  req1_oprB = b; req1_shamt = a[4:0];
        end
    endtask

    // Waits, with a bound, until requester id (0/1) or either requester (2)
    // sees ready. Returns with time just before the accepting edge.
    task automatic wait_ready(input int id, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        #1;
        while (n < 20) begin
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready) ||
                (id == 2 && (req0_ready || req1_ready))) begin
                ok = 1'b1;
                break;
            end
            step();
            n++;
        end
    endtask

    // Bounded wait for rsp_valid, counting cycles from the accept edge.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_done++;
        check({tag, "_vld_drop"}, 64'(rsp_valid), 64'd0);
        check({tag, "_ops_done"}, 64'(ops_done), 64'(exp_done));
    endtask

    // One op from a single requester.
    // bp = number of cycles the response is held back before it is accepted.
    task automatic do_op(input int id, input logic [5:0] op, input logic [1:0] ww,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_d, input logic exp_err, input int exp_lat,
                         input int bp, input string tag);
        bit          ok;
        bit          hold_ok;
        bit          bp_ok;
        int          lat;
        logic [63:0] held;
        drive(id, 1'b1, op, ww, a, b);
        wait_ready(id, ok);
        check({tag, "_accept"}, 64'(ok), 64'd1);
        if (!ok) begin
            drive(id, 1'b0, op, ww, a, b);
            return;
        end
        step();
        drive(id, 1'b0, op, ww, a, b);
        lat     = 0;
        hold_ok = 1'b1;
        while (!rsp_valid && lat < 20) begin
            hold_ok &= (alu_oprA == a) && (alu_oprB == b) && (alu_op == op) &&
                       (alu_ww == ww) && (alu_shift_amount == a[4:0]);
            step();
            lat++;
        end
        check({tag, "_latency"},  64'(lat),      64'(exp_lat));
        check({tag, "_alu_hold"}, 64'(hold_ok),  64'd1);
        check({tag, "_data"},     rsp_data,      exp_d);
        check({tag, "_id"},       64'(rsp_id),   64'(id));
        check({tag, "_err"},      64'(rsp_err),  64'(exp_err));
        if (bp > 0) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            held  = rsp_data;
            bp_ok = 1'b1;
            for (int i = 0; i < bp; i++) begin
                bp_ok &= rsp_valid && (rsp_data == held) && !req0_ready && !req1_ready &&
                         (int'(ops_done) == exp_done);
                step();
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            check({tag, "_bp_stable"}, 64'(bp_ok), 64'd1);
        end
        handshake(tag);
    endtask

    initial begin
        bit          ok;
        bit          quiet;
        int          lat;
        int          win;
        logic [63:0] a0, b0, e0, a1, b1, e1;

        n_tests    = 0;
        n_fail     = 0;
        exp_done   = 0;
        reset_n    = 1'b0;
        rsp_ready  = 1'b0;
        drive(0, 1'b0, 6'd0, 2'd0, 64'd0, 64'd0);
        drive(1, 1'b0, 6'd0, 2'd0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_rsp_valid", 64'(rsp_valid),  64'd0);
        check("rst_alu_op",    64'(alu_op),     64'd0);
        check("rst_alu_oprA",  alu_oprA,        64'd0);
        check("rst_rsp_id",    64'(rsp_id),     64'd0);
        check("rst_ops_done",  64'(ops_done),   64'd0);
        check("rst_ready0",    64'(req0_ready), 64'd0);
        reset_n = 1'b1;
        step();

        // Directed single-requester ops
        do_op(0, 6'd6, 2'd2, 64'h00000001_00000002, 64'h00000003_00000004,
              64'h00000004_00000006, 1'b0, ALU_LAT, 0, "vadd_w");
        do_op(1, 6'd8, 2'd2, 64'h00000003_FFFFFFFF, 64'h00000005_FFFFFFFF,
              64'h00000000_0000000F, 1'b0, MUL_LAT, 0, "vmuleu_w");
        do_op(0, 6'd6, 2'd2, 64'h00000010_00000020, 64'h00000001_00000002,
              64'h00000011_00000022, 1'b0, ALU_LAT, 5, "backpress");
        do_op(1, 6'd19, 2'd2, 64'h12345678_9ABCDEF0, 64'h11111111_22222222,
              64'd0, 1'b1, ALU_LAT, 0, "illegal_19");
        do_op(0, 6'd8, 2'd3, 64'h00000003_00000003, 64'h00000005_00000005,
              64'd0, 1'b1, MUL_LAT, 0, "illegal_mul_d");
        do_op(0, 6'd6, 2'd2, 64'hFFFFFFFF_00000007, 64'h00000001_00000008,
              64'h00000000_0000000F, 1'b0, ALU_LAT, 0, "legal_after");

        // Reset while in EXEC: op is discarded, outputs clear immediately
        drive(1, 1'b1, 6'd8, 2'd2, 64'h00000007_00000000, 64'h00000009_00000000);
        wait_ready(1, ok);
        check("midrst_accept", 64'(ok), 64'd1);
        step();
        drive(1, 1'b0, 6'd8, 2'd2, 64'd0, 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_alu_oprA",  alu_oprA,        64'd0);
        check("midrst_alu_op",    64'(alu_op),     64'd0);
        check("midrst_rsp_data",  rsp_data,        64'd0);
        check("midrst_rsp_id",    64'(rsp_id),     64'd0);
        check("midrst_ops_done",  64'(ops_done),   64'd0);
        exp_done = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        quiet   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            quiet &= !rsp_valid;
            step();
        end
        check("midrst_no_stale", 64'(quiet), 64'd1);

        // Contention: both valid for every round; grants must alternate 0,1,0,1
        for (int r = 0; r < 4; r++) begin
            a0 = {32'(r + 1), 32'h1};  b0 = {32'h2, 32'h2};   e0 = {32'(r + 3), 32'h3};
            a1 = {32'h10, 32'(r + 16)}; b1 = {32'h20, 32'h20}; e1 = {32'h30, 32'(r + 48)};
            drive(0, 1'b1, 6'd6, 2'd2, a0, b0);
            drive(1, 1'b1, 6'd6, 2'd2, a1, b1);
            wait_ready(2, ok);
            check($sformatf("cont%0d_accept", r), 64'(ok), 64'd1);
            check($sformatf("cont%0d_grant", r), 64'(req1_ready), 64'(r % 2));
            check($sformatf("cont%0d_one_ready", r), 64'(req0_ready & req1_ready), 64'd0);
            step();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            wait_rsp(lat);
            win = r % 2;
            check($sformatf("cont%0d_latency", r), 64'(lat), 64'(ALU_LAT));
            check($sformatf("cont%0d_id", r), 64'(rsp_id), 64'(win));
            check($sformatf("cont%0d_data", r), rsp_data, (win == 1) ? e1 : e0);
            handshake($sformatf("cont%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Two-requester issue controller that shares the single combinational 64-bit vector ALU (alu module) between requesters, e.g. the core pipeline and the NIC/NoC packet-processing path. It round-robin-arbitrates requests, registers and holds operands on the ALU inputs for an op-dependent number of cycles, and captures the result. It returns the result with requester ID and error flag over a valid/ready response channel. Instantiated next to alu; drives its inputs and samples its result.

Parameters:
MUL_LAT, 2, cycles ALU inputs are held before result capture for ops 8-11 (VMULEU/VMULOU/VSQEU/VSQOU); legal range 1-15
ALU_LAT, 1, cycles held for all other ops; legal range 1-15
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_op  in  [0:5]  ALU opcode
req0_ww  in  [0:1]  element width (0=B,1=H,2=W,3=D)
req0_oprA, req0_oprB  in  [0:63] each  operands
req0_shamt  in  [0:4]  immediate shift amount
req1_*  same set as req0_* for requester 1
alu_oprA, alu_oprB  out  [0:63]  to alu inputs
alu_shift_amount  out  [0:4]  to alu
alu_op  out  [0:5]  to alu
alu_ww  out  [0:1]  to alu
alu_result  in  [0:63]  from alu
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the op
rsp_data  out  [0:63]  captured ALU result
rsp_err  out  1  op was illegal
ops_done  out  [0:CNT_W-1]  count of completed responses, wraps

Behaviour:
- Bit 0 is MSB on all buses, matching alu.
- Reset (async assert, sync release): state=IDLE; all alu_* outputs, rsp_data, rsp_id, rsp_err, ops_done = 0; rsp_valid=0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant: sole valid requester wins. If both are valid, the requester != last_grant wins.
- IDLE, ready: reqN_ready=1 only for the granted requester, combinational from reqN_valid and state; both readys are 0 outside IDLE.
- IDLE, accept on valid&&ready at edge E0:
  - latch op/ww/oprA/oprB/shamt into alu_* registers; rsp_id=N; last_grant=N;
  - rsp_err = (op==0 || op>18 || (op in 8..11 && ww==3));
  - cnt = L-1, where L=MUL_LAT for ops 8-11, else ALU_LAT;
  - go to EXEC.
- EXEC: alu_* held constant. If cnt!=0, decrement. If cnt==0, rsp_data<=alu_result, rsp_valid<=1, go to RESP. rsp_valid therefore rises exactly L cycles after E0.
- RESP: rsp_valid, rsp_data, rsp_id and rsp_err held stable until rsp_ready. On the handshake: rsp_valid<=0, ops_done+=1 (wraps at 2^CNT_W-1 -> 0), go to IDLE. No new request is accepted in the handshake cycle.
- Throughput: at most one op per L+2 cycles; the ALU is never shared mid-op.
- Illegal ops still execute for ALU_LAT/MUL_LAT cycles; rsp_data = whatever alu returns (0 by alu definition); rsp_err=1.
- A requester may drop valid before ready without penalty; arbitration is re-evaluated every IDLE cycle. Request fields are don't-care when valid=0.
- alu_* keep the last op's values after completion (no toggling in IDLE).
- Reset mid-EXEC/RESP: the op is discarded, no response is produced, and all outputs take reset values immediately.
- rsp_ready held high: the response completes in its first RESP cycle.

Test Plan:
- VADD W: req0 op=6 ww=2 oprA=0x00000001_00000002 oprB=0x00000003_00000004 -> rsp_valid exactly 1 cycle after accept, rsp_data=0x00000004_00000006, rsp_id=0, rsp_err=0, ops_done=1.
- VMULEU W, MUL_LAT=2: req1 op=8 ww=2 oprA=0x00000003_FFFFFFFF oprB=0x00000005_FFFFFFFF -> rsp_valid 2 cycles after accept, rsp_data=0x00000000_0000000F, rsp_id=1; alu_* stable across both cycles.
- Contention: both valid for 4 consecutive ops after reset -> grants 0,1,0,1; each response matches its own operands.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req*_ready=0 throughout, ops_done unchanged until the handshake.
- Illegal op: op=19, then op=8 ww=3 -> rsp_data=0, rsp_err=1 for both; next legal op has rsp_err=0.
- Reset mid-op: drop reset_n in EXEC -> rsp_valid=0 and all outputs 0 asynchronously; after release, req0 and req1 both valid -> req0 granted first; no stale response appears.
